field_draw_scheduler: RTL and testbench

- Frame-level controller that sequences the per-cell vector renderer (draw_block) across the whole velocity field.
- For each field cell, in row-major order, it reads one word from the field BRAM (bram_sdp, 1-cycle registered read) and unpacks xn/yn/mag.
- It computes the cell's pixel-centre origin in Q16.16, pulses the renderer start, and waits for the renderer's done or a watchdog timeout.
- It sits between the top-level frame trigger and draw_block, and replaces the ad-hoc sequencing in the block-drawing wrapper.

---
 rtl/field_draw_scheduler_if.sv | 25 ++
 rtl/field_draw_scheduler.sv | 149 ++++++++++++++
 tb/tb_field_draw_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/field_draw_scheduler_if.sv
// rtl/field_draw_scheduler_if.sv - field BRAM read port and draw_block handshake bundle
interface field_draw_scheduler_if #(
  parameter int FIELD_ADDRW = 6,
  parameter int FIELD_DATAW = 96
);
  logic [FIELD_ADDRW-1:0] field_addr;
  logic [FIELD_DATAW-1:0] field_data;
  logic                   blk_start;
  logic                   blk_done;
  logic [31:0]            block_x;
  logic [31:0]            block_y;
  logic [31:0]            xn;
  logic [31:0]            yn;
  logic [31:0]            mag;

  modport master (
    output field_addr, blk_start, block_x, block_y, xn, yn, mag,
    input  field_data, blk_done
  );

  modport slave (
    input  field_addr, blk_start, block_x, block_y, xn, yn, mag,
    output field_data, blk_done
  );
endinterface

// File: rtl/field_draw_scheduler.sv
// rtl/field_draw_scheduler.sv - walks the velocity field row-major and fires draw_block once per cell
module field_draw_scheduler #(
  parameter int FIELD_WIDTH  = 8,
  parameter int FIELD_HEIGHT = 6,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int FIELD_DATAW  = 96,
  parameter int BLOCK_SIZE   = 80,
  parameter int TIMEOUT      = 65535,
  parameter int TOW          = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic timeout_err,
  field_draw_scheduler_if.master bus
);
  localparam int XW = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;
  localparam int YW = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;
  localparam logic [XW-1:0]          LAST_X    = XW'(FIELD_WIDTH - 1);
  localparam logic [FIELD_ADDRW-1:0] LAST_ADDR = FIELD_ADDRW'(FIELD_SIZE - 1);
  localparam logic [TOW-1:0]         WD_LAST   = TOW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, RDWAIT, LATCH, FIRE, WAIT_BLK, NEXT
  } state_t;

  state_t                 state, state_n;
  logic [XW-1:0]          fx, fx_n;
  logic [YW-1:0]          fy, fy_n;
  logic [TOW-1:0]         wd, wd_n;
  logic                   err_q, err_n;
  logic [FIELD_ADDRW-1:0] addr_q, addr_n;
  logic [31:0]            bx_q, bx_n, by_q, by_n;
  logic [31:0]            xn_q, xn_n, yn_q, yn_n, mag_q, mag_n;
  logic                   last_cell;

  // field_addr tracks the cell index, so it doubles as the end-of-frame marker
  assign last_cell = (addr_q == LAST_ADDR);

  always_comb begin
    state_n = state;
    fx_n    = fx;
    fy_n    = fy;
    wd_n    = wd;
    err_n   = err_q;
    addr_n  = addr_q;
    bx_n    = bx_q;
    by_n    = by_q;
    xn_n    = xn_q;
    yn_n    = yn_q;
    mag_n   = mag_q;
    case (state)
      IDLE: begin
        if (start) begin
          fx_n    = '0;
          fy_n    = '0;
          err_n   = 1'b0;
          addr_n  = '0;
          state_n = ADDR;
        end
      end
      ADDR:   state_n = RDWAIT;
      RDWAIT: state_n = LATCH;
      LATCH: begin
        xn_n    = bus.field_data[FIELD_DATAW-1 -: 32];
        yn_n    = bus.field_data[FIELD_DATAW-33 -: 32];
        mag_n   = bus.field_data[31:0];
        bx_n    = (32'(fx) * 32'(BLOCK_SIZE) + 32'(BLOCK_SIZE / 2)) << 16;
        by_n    = (32'(fy) * 32'(BLOCK_SIZE) + 32'(BLOCK_SIZE / 2)) << 16;
        state_n = FIRE;
      end
      FIRE: begin
        wd_n    = '0;
        state_n = WAIT_BLK;
      end
      WAIT_BLK: begin
        // a completion on the timeout cycle still counts as a clean finish
        if (bus.blk_done) begin
          state_n = NEXT;
        end else if (wd == WD_LAST) begin
          err_n   = 1'b1;
          state_n = NEXT;
        end else begin
          wd_n = wd + TOW'(1);
        end
      end
      NEXT: begin
        if (last_cell) begin
          fx_n    = '0;
          fy_n    = '0;
          addr_n  = '0;
          state_n = IDLE;
        end else begin
          if (fx == LAST_X) begin
            fx_n = '0;
            fy_n = fy + YW'(1);
          end else begin
            fx_n = fx + XW'(1);
          end
          addr_n  = FIELD_ADDRW'(32'(fy_n) * 32'(FIELD_WIDTH) + 32'(fx_n));
          state_n = ADDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      fx     <= '0;
      fy     <= '0;
      wd     <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      xn_q   <= '0;
      yn_q   <= '0;
      mag_q  <= '0;
    end else begin
      state  <= state_n;
      fx     <= fx_n;
      fy     <= fy_n;
      wd     <= wd_n;
      err_q  <= err_n;
      addr_q <= addr_n;
      bx_q   <= bx_n;
      by_q   <= by_n;
      xn_q   <= xn_n;
      yn_q   <= yn_n;
      mag_q  <= mag_n;
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == NEXT) && last_cell;
  assign timeout_err    = err_q;
  assign bus.blk_start  = (state == FIRE);
  assign bus.field_addr = addr_q;
  assign bus.block_x    = bx_q;
  assign bus.block_y    = by_q;
  assign bus.xn         = xn_q;
  assign bus.yn         = yn_q;
  assign bus.mag        = mag_q;
endmodule

// File: tb/tb_field_draw_scheduler.sv
// tb/tb_field_draw_scheduler.sv - directed frames checked against a cell-level scheduling model
`timescale 1ns/1ps
module tb_field_draw_scheduler;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int N     = W * H;
  localparam int AW    = $clog2(N);
  localparam int DW    = 96;
  localparam int BS    = 80;
  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n, start, busy, done, timeout_err;

  field_draw_scheduler_if #(.FIELD_ADDRW(AW), .FIELD_DATAW(DW)) bus ();

  field_draw_scheduler #(
    .FIELD_WIDTH(W), .FIELD_HEIGHT(H), .BLOCK_SIZE(BS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, mode = 1;
  int exp_cell = 0, exp_gap = 0, last_fire = 0, start_cyc = 0, last_eff = 0;
  int due = -1, stray_at = -1, done_cnt = 0, gap4 = 0;
  bit exp_err = 1'b0, exp_busy = 1'b0, prev_done = 1'b0;
  logic [31:0] snap_bx [N];
  logic [31:0] snap_by [N];
  logic [31:0] snap_xn [N];
  logic [31:0] snap_yn [N];
  logic [31:0] snap_mag [N];

  function automatic logic [DW-1:0] mem_word(input int k);
    if (k == 9) return {32'h0000B4FD, 32'hFFFF4B03, 32'h00140000};
    return {32'h1000_0000 + 32'(k), 32'h2000_0000 ^ 32'(k * 3), 32'h3000_0000 + 32'(k * 7)};
  endfunction

  // renderer latency per cell; anything beyond TO means the renderer never answers
  function automatic int cell_delay(input int m, input int k);
    case (m)
      0:       return 10;
      2:       return (k == 3) ? NEVER : (k % 5) + 1;
      3:       return (k == 2) ? TO : 3;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  always @(posedge clk) bus.field_data <= mem_word(int'(bus.field_addr));

  always @(negedge clk) begin : monitor
    int d, eff;
    logic [DW-1:0] w;
    cyc++;
    if (!rst_n) begin
      exp_busy     = 1'b0;
      exp_cell     = 0;
      due          = -1;
      stray_at     = -1;
      prev_done    = 1'b0;
      bus.blk_done = 1'b0;
    end else begin
      check("busy", busy, exp_busy);
      if (prev_done) check("done_width", done, 0);
      prev_done = done;
      if (bus.blk_start) begin
        w = mem_word(exp_cell);
        check("field_addr", bus.field_addr, exp_cell);
        check("block_x", bus.block_x, ((exp_cell % W) * BS + BS / 2) << 16);
        check("block_y", bus.block_y, ((exp_cell / W) * BS + BS / 2) << 16);
        check("xn", bus.xn, w[95:64]);
        check("yn", bus.yn, w[63:32]);
        check("mag", bus.mag, w[31:0]);
        check("timeout_err_run", timeout_err, exp_err);
        if (exp_cell == 0) check("first_latency", cyc - start_cyc, 4);
        else check("start_gap", cyc - last_fire, exp_gap);
        if (exp_cell == 4) gap4 = cyc - last_fire;
        if (exp_cell < N) begin
          snap_bx[exp_cell]  = bus.block_x;
          snap_by[exp_cell]  = bus.block_y;
          snap_xn[exp_cell]  = bus.xn;
          snap_yn[exp_cell]  = bus.yn;
          snap_mag[exp_cell] = bus.mag;
        end
        d   = cell_delay(mode, exp_cell);
        eff = (d > TO) ? TO : d;
        if (d > TO) begin
          exp_err  = 1'b1;
          due      = -1;
          stray_at = -1;
        end else begin
          due      = cyc + d;
          stray_at = (mode == 2) ? due + 2 : -1;
        end
        exp_gap   = eff + 5;
        last_eff  = eff;
        last_fire = cyc;
        exp_cell++;
      end
      if (done) begin
        done_cnt++;
        check("done_cell_count", exp_cell, N);
        check("done_time", cyc - last_fire, last_eff + 1);
        check("done_timeout_err", timeout_err, exp_err);
        exp_busy = 1'b0;
      end
      if (start && !busy) begin
        exp_busy  = 1'b1;
        exp_err   = 1'b0;
        exp_cell  = 0;
        start_cyc = cyc;
      end
      bus.blk_done = (cyc == due) || (cyc == stray_at);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int m, input string tag, input bit err_end,
                           input bit mid_start, input bit start_on_done);
    mode     = m;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mid_start) begin
      for (int i = 0; i < 2000 && exp_cell < 20; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (start_on_done) begin
      for (int i = 0; i < 4000 && exp_cell < N; i++) tick();
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
    check({tag, "_done_seen"}, done_cnt, 1);
    repeat (4) tick();
    check({tag, "_pulses"}, exp_cell, N);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_timeout_err_end"}, timeout_err, err_end);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_blk_start", bus.blk_start, 0);
    check("rst_field_addr", bus.field_addr, 0);
    check("rst_block_x", bus.block_x, 0);
    check("rst_block_y", bus.block_y, 0);
    check("rst_xn", bus.xn, 0);
    check("rst_mag", bus.mag, 0);
    rst_n = 1'b1;
    tick();

    mode     = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && exp_cell < 11; i++) tick();
    check("midrst_reached_cell10", exp_cell, 11);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_blk_start", bus.blk_start, 0);
    check("midrst_done", done, 0);
    check("midrst_field_addr", bus.field_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", done_cnt, 0);

    run_frame(1, "normal", 1'b0, 1'b0, 1'b0);
    check("cell9_block_x", snap_bx[9], 32'h00780000);
    check("cell9_block_y", snap_by[9], 32'h00780000);
    check("cell9_xn", snap_xn[9], 32'h0000B4FD);
    check("cell9_yn", snap_yn[9], 32'hFFFF4B03);
    check("cell9_mag", snap_mag[9], 32'h00140000);
    check("cell8_block_x", snap_bx[8], 32'h00280000);
    check("cell8_block_y", snap_by[8], 32'h00780000);
    check("cell47_block_x", snap_bx[47], 32'h02580000);
    check("cell47_block_y", snap_by[47], 32'h01B80000);

    run_frame(2, "timeout", 1'b1, 1'b1, 1'b0);
    check("timeout_cell4_gap", gap4, 21);

    run_frame(3, "coincide", 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
